// File: rtl/phy_pkg.sv
// Shared definitions for the N-lane PHY transmitter.
//   COM_SYM_DEF / IDL_SYM_DEF : default 8-bit comma and idle symbols
//   phy_state_e                : link-training state encoding
package phy_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } phy_state_e;

endpackage

// File: rtl/phy_ser_lane.sv
// One serial lane: a W-bit load/shift register, MSB out first.
//   clk_i   : bit clock
//   clr_i   : synchronous clear (highest priority)
//   load_i  : parallel load of data_i
//   shift_i : shift left by one, zero fill
//   data_i  : word to load
//   ser_o   : serial output (register MSB)
module phy_ser_lane #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         ser_o
);

    logic [W-1:0] shreg_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[W-2:0], 1'b0};
        end
    end

    assign ser_o = shreg_q[W-1];

endmodule

// File: rtl/phy_tx_nlane.sv
// N-lane PHY transmitter with link training.
// Each enable (or reset release with enable high) sends SYNC_WORDS comma
// words on every lane, then streams data words; a lane with validin low
// in a data slot sends the idle symbol.
//   clk_8f     : bit clock
//   reset      : synchronous, active-high
//   enable     : link enable; low forces the link off
//   validin    : per-lane data valid, sampled with entrada
//   entrada    : lane i word = entrada[i*W +: W]
//   ready      : high in the cycle whose closing edge samples entrada
//   active     : high while in DATA
//   salida_ser : serial bit per lane, MSB first
module phy_tx_nlane
    import phy_pkg::*;
#(
    parameter int unsigned   LANES      = 2,
    parameter int unsigned   W          = 8,
    parameter int unsigned   SYNC_WORDS = 4,
    parameter logic [W-1:0]  COM_SYM    = W'(COM_SYM_DEF),
    parameter logic [W-1:0]  IDL_SYM    = W'(IDL_SYM_DEF)
) (
    input  logic               clk_8f,
    input  logic               reset,
    input  logic               enable,
    input  logic [LANES-1:0]   validin,
    input  logic [LANES*W-1:0] entrada,
    output logic               ready,
    output logic               active,
    output logic [LANES-1:0]   salida_ser
);

    localparam int unsigned CNT_W  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned WCNT_W = $clog2(SYNC_WORDS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(W - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SYNC_WORDS - 1);

    phy_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic word_end;
    logic sync_last;
    logic lane_clr;
    logic lane_load;
    logic lane_shift;
    logic load_com;

    assign word_end  = (cnt_q == CNT_LAST);
    assign sync_last = (wcnt_q == WCNT_LAST);

    // State register
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state and counters; a falling enable beats a word boundary
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            OFF: begin
                if (enable) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
            end
            SYNC, DATA: begin
                if (!enable) begin
                    state_d = OFF;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end else if (word_end) begin
                    cnt_d = '0;
                    if (state_q == SYNC) begin
                        if (sync_last) begin
                            state_d = DATA;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // Outputs and lane controls
    always_comb begin
        lane_clr   = reset;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        load_com   = 1'b0;
        ready      = 1'b0;
        active     = (state_q == DATA);
        if (!reset) begin
            case (state_q)
                OFF: begin
                    if (enable) begin
                        lane_load = 1'b1;
                        load_com  = 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (!enable) begin
                        lane_clr = 1'b1;
                    end else if (word_end) begin
                        lane_load = 1'b1;
                        load_com  = (state_q == SYNC) && !sync_last;
                        ready     = (state_q == DATA) || sync_last;
                    end else begin
                        lane_shift = 1'b1;
                    end
                end
                default: lane_clr = 1'b1;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0] word;

        always_comb begin
            if (load_com) begin
                word = COM_SYM;
            end else if (validin[g]) begin
                word = entrada[g*W +: W];
            end else begin
                word = IDL_SYM;
            end
        end

        phy_ser_lane #(.W(W)) u_lane (
            .clk_i   (clk_8f),
            .clr_i   (lane_clr),
            .load_i  (lane_load),
            .shift_i (lane_shift),
            .data_i  (word),
            .ser_o   (salida_ser[g])
        );
    end

endmodule

// File: tb/tb_phy_tx_nlane.sv
module tb_phy_tx_nlane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Instance A: default geometry, 2 lanes x 8 bits, 4 sync words
    logic        rst_a, en_a, rdy_a, act_a;
    logic [1:0]  vin_a, ser_a;
    logic [15:0] ent_a;

    phy_tx_nlane #(
        .LANES(2), .W(8), .SYNC_WORDS(4), .COM_SYM(8'hBC), .IDL_SYM(8'h7C)
    ) dut_a (
        .clk_8f(clk), .reset(rst_a), .enable(en_a), .validin(vin_a),
        .entrada(ent_a), .ready(rdy_a), .active(act_a), .salida_ser(ser_a)
    );

    // Instance B: parameter sweep, 4 lanes x 10 bits, 2 sync words
    logic        rst_b, en_b, rdy_b, act_b;
    logic [3:0]  vin_b, ser_b;
    logic [39:0] ent_b;

    phy_tx_nlane #(
        .LANES(4), .W(10), .SYNC_WORDS(2), .COM_SYM(10'h0BC), .IDL_SYM(10'h07C)
    ) dut_b (
        .clk_8f(clk), .reset(rst_b), .enable(en_b), .validin(vin_b),
        .entrada(ent_b), .ready(rdy_b), .active(act_b), .salida_ser(ser_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at the edge that takes OFF->SYNC; ends inside the first ready cycle.
    task automatic train_a(input string tag);
        logic [31:0] l0, l1;
        int unsigned early;
        l0 = '0; l1 = '0; early = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            l0 = {l0[30:0], ser_a[0]};
            l1 = {l1[30:0], ser_a[1]};
            if (k < 31 && rdy_a) early++;
            if (k == 31) begin
                check($sformatf("%s first_ready", tag), 64'(rdy_a), 64'd1);
                check($sformatf("%s active_in_sync", tag), 64'(act_a), 64'd0);
            end
        end
        check($sformatf("%s lane0_com", tag), 64'(l0), 64'hBCBCBCBC);
        check($sformatf("%s lane1_com", tag), 64'(l1), 64'hBCBCBCBC);
        check($sformatf("%s early_ready", tag), 64'(early), 64'd0);
    endtask

    // Called inside a ready cycle; presents one word and serialises it.
    task automatic word_a(input string tag, input logic [15:0] ent, input logic [1:0] vin,
                          input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] l0, l1;
        int unsigned early;
        l0 = '0; l1 = '0; early = 0;
        ent_a = ent;
        vin_a = vin;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 0) begin
                ent_a = 16'hFFFF;   // must be ignored outside ready cycles
                vin_a = 2'b11;
                check($sformatf("%s active", tag), 64'(act_a), 64'd1);
            end
            l0 = {l0[6:0], ser_a[0]};
            l1 = {l1[6:0], ser_a[1]};
            if (j < 7 && rdy_a) early++;
            if (j == 7) check($sformatf("%s next_ready", tag), 64'(rdy_a), 64'd1);
        end
        check($sformatf("%s lane0", tag), 64'(l0), 64'(e0));
        check($sformatf("%s lane1", tag), 64'(l1), 64'(e1));
        check($sformatf("%s ready_period", tag), 64'(early), 64'd0);
    endtask

    initial begin
        logic [3:0]  b0, b1;
        logic [19:0] sl [4];
        logic [9:0]  got [4];
        logic [9:0]  exp [4];
        logic [63:0] r;
        logic [39:0] ent;
        logic [3:0]  vin;
        int unsigned early;

        rst_a = 1'b1; en_a = 1'b1; vin_a = '0; ent_a = '0;
        rst_b = 1'b1; en_b = 1'b0; vin_b = '0; ent_b = '0;

        // Reset held with enable high
        for (int i = 0; i < 3; i++) tick();
        check("rst ser", 64'(ser_a), 64'd0);
        check("rst ready", 64'(rdy_a), 64'd0);
        check("rst active", 64'(act_a), 64'd0);

        rst_a = 1'b0;
        train_a("post_reset");
        word_a("data_11", 16'hA53C, 2'b11, 8'h3C, 8'hA5);
        word_a("data_01", 16'h6655, 2'b01, 8'h55, 8'h7C);
        word_a("data_10", 16'h8112, 2'b10, 8'h7C, 8'h81);

        // Mid-word disable at cnt=3
        ent_a = 16'hA53C; vin_a = 2'b11;
        b0 = '0; b1 = '0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 0) begin ent_a = '0; vin_a = '0; end
            b0 = {b0[2:0], ser_a[0]};
            b1 = {b1[2:0], ser_a[1]};
        end
        check("midword lane0_bits", 64'(b0), 64'h3);
        check("midword lane1_bits", 64'(b1), 64'hA);
        en_a = 1'b0;
        tick();
        check("disable ser", 64'(ser_a), 64'd0);
        check("disable active", 64'(act_a), 64'd0);
        check("disable ready", 64'(rdy_a), 64'd0);
        tick(); tick();
        check("off hold ser", 64'(ser_a), 64'd0);
        en_a = 1'b1;
        train_a("reenable");
        word_a("after_reenable", 16'h0FF0, 2'b11, 8'hF0, 8'h0F);

        // Reset during the third sync word
        en_a = 1'b0;
        tick();
        check("off active", 64'(act_a), 64'd0);
        en_a = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        rst_a = 1'b1;
        tick();
        check("midsync rst ser", 64'(ser_a), 64'd0);
        check("midsync rst ready", 64'(rdy_a), 64'd0);
        check("midsync rst active", 64'(act_a), 64'd0);
        rst_a = 1'b0;
        train_a("after_midsync_rst");
        word_a("after_midsync_word", 16'hC35A, 2'b11, 8'h5A, 8'hC3);

        // Parameter sweep instance
        tick();
        rst_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 4; i++) sl[i] = '0;
        early = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int i = 0; i < 4; i++) sl[i] = {sl[i][18:0], ser_b[i]};
            if (k < 19 && rdy_b) early++;
            if (k == 19) check("sweep first_ready", 64'(rdy_b), 64'd1);
        end
        check("sweep early_ready", 64'(early), 64'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("sweep com lane%0d", i), 64'(sl[i]), 64'({10'h0BC, 10'h0BC}));

        for (int w = 0; w < 200; w++) begin
            r = {$urandom(), $urandom()};
            ent = r[39:0];
            vin = 4'($urandom());
            for (int i = 0; i < 4; i++) begin
                exp[i] = vin[i] ? ent[i*10 +: 10] : 10'h07C;
                got[i] = '0;
            end
            ent_b = ent;
            vin_b = vin;
            early = 0;
            for (int j = 0; j < 10; j++) begin
                tick();
                if (j == 0) begin
                    r = {$urandom(), $urandom()};
                    ent_b = r[39:0];
                    vin_b = 4'($urandom());
                end
                for (int i = 0; i < 4; i++) got[i] = {got[i][8:0], ser_b[i]};
                if (j < 9 && rdy_b) early++;
                if (j == 9) check($sformatf("sweep w%0d ready", w), 64'(rdy_b), 64'd1);
            end
            check($sformatf("sweep w%0d period", w), 64'(early), 64'd0);
            for (int i = 0; i < 4; i++)
                check($sformatf("sweep w%0d lane%0d", w, i), 64'(got[i]), 64'(exp[i]));
        end
        check("sweep active", 64'(act_b), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
